// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
//
// Request/response sequencer for an external combinational 64-bit ALU.
// One request is taken at a time. A legal operation is issued to the ALU
// through registered alu_a/alu_b/alu_sel. The controller then waits a fixed
// number of settle cycles and captures the ALU result into the response
// registers. The response is held until the consumer takes it.
// Illegal opcodes are answered at once with an error response and are not
// issued to the ALU.
//
// Parameters
//   SIMPLE_WAIT  settle cycles for add/sub/and/or (1..15)
//   MULDIV_WAIT  settle cycles for mul/div        (1..15)
//
// Configuration macro
//   ALU_CTRL_DIVZERO_TRAP_EN  when defined, div with req_b == 0 is answered
//                             like an illegal opcode (err=1, result 0, ALU
//                             registers untouched). When undefined, it goes
//                             down the normal div path.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_ready is high only when idle
//   req_op[2:0]          001 add, 010 sub, 011 mul, 100 div, 101 and, 110 or
//   req_a, req_b [63:0]  operands
//   rsp_valid/rsp_ready  response handshake
//   rsp_result[63:0]     captured ALU result (0 on error)
//   rsp_z, rsp_o, rsp_err  zero, overflow and error flags
//   alu_a, alu_b, alu_sel  registered drive to the ALU
//   alu_result, alu_o    ALU result and overflow flag
// -----------------------------------------------------------------------------
module alu_ctrl #(
   parameter int unsigned SIMPLE_WAIT = 1,
   parameter int unsigned MULDIV_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result,
   output logic        rsp_z,
   output logic        rsp_o,
   output logic        rsp_err,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   output logic [2:0]  alu_sel,
   input  logic [63:0] alu_result,
   input  logic        alu_o
);

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;

   localparam logic [3:0] SIMPLE_N = 4'(SIMPLE_WAIT);
   localparam logic [3:0] MULDIV_N = 4'(MULDIV_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t     state_reg;
   logic [3:0] count_reg;

   logic       op_legal;
   logic       div_trap;
   logic       reject;
   logic [3:0] wait_n;
   logic       keep_o;

   // Decode of the incoming opcode; only used while idle.
   always_comb begin
      op_legal = 1'b0;
      case (req_op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR: op_legal = 1'b1;
         default:                                      op_legal = 1'b0;
      endcase
   end

`ifdef ALU_CTRL_DIVZERO_TRAP_EN
   assign div_trap = (req_op == OP_DIV) && (req_b == 64'd0);
`else
   assign div_trap = 1'b0;
`endif

   // Requests answered immediately with an error, without touching the ALU.
   assign reject = !op_legal || div_trap;

   assign wait_n = ((req_op == OP_MUL) || (req_op == OP_DIV)) ? MULDIV_N : SIMPLE_N;

   // alu_sel still holds the issued op at capture time, so the overflow
   // qualification uses it rather than the (possibly changed) req_op.
   assign keep_o = (alu_sel == OP_ADD) || (alu_sel == OP_SUB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         count_reg  <= 4'd0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_result <= 64'd0;
         rsp_z      <= 1'b0;
         rsp_o      <= 1'b0;
         rsp_err    <= 1'b0;
         alu_a      <= 64'd0;
         alu_b      <= 64'd0;
         alu_sel    <= 3'b000;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (reject) begin
                     rsp_result <= 64'd0;
                     rsp_z      <= 1'b0;
                     rsp_o      <= 1'b0;
                     rsp_err    <= 1'b1;
                     rsp_valid  <= 1'b1;
                     state_reg  <= ST_RESP;
                  end else begin
                     alu_a     <= req_a;
                     alu_b     <= req_b;
                     alu_sel   <= req_op;
                     count_reg <= wait_n;
                     state_reg <= ST_WAIT;
                  end
               end
            end

            ST_WAIT: begin
               // The edge that sees count==1 is the N-th edge after issue,
               // so the response becomes visible exactly N cycles after T0.
               if (count_reg == 4'd1) begin
                  rsp_result <= alu_result;
                  rsp_z      <= ~|alu_result;
                  rsp_o      <= keep_o & alu_o;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  count_reg  <= 4'd0;
                  state_reg  <= ST_RESP;
               end else begin
                  count_reg <= count_reg - 4'd1;
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
               count_reg <= 4'd0;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
